// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU register file: default geometry,
// the register index type and the index of the optional zero register.
package cpu_pkg;

    localparam int CPU_DATA_W = 16;
    localparam int CPU_DEPTH  = 8;
    localparam int CPU_ADDR_W = $clog2(CPU_DEPTH);

    // Register index at the default depth
    typedef logic [CPU_ADDR_W-1:0] reg_idx_t;

    // Register that reads as zero when the hardwired-zero option is enabled
    localparam int ZERO_IDX = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard. An issue marks its destination busy and a
// writeback retires it; when both hit the same register in one cycle the
// newer producer (the issue) wins. The zero register never goes busy.
module rf_scoreboard
    import cpu_pkg::*;
#(
    parameter int  DEPTH    = CPU_DEPTH,
    parameter bit  ZERO_REG = 1'b0,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              set_valid,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic              clr_valid,
    output logic [DEPTH-1:0]  busy
);

    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_bit
            if (ZERO_REG && (gi == ZERO_IDX)) begin : g_zero
                // Hardwired-zero register can never have a pending producer
                assign busy_next[gi] = 1'b0;
            end else begin : g_live
                logic set_hit;
                logic clr_hit;
                assign set_hit = set_valid && (set_idx == ADDR_W'(gi));
                assign clr_hit = clr_valid && (clr_idx == ADDR_W'(gi));
                // Set has priority over clear for the same register
                assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
            end
        end
    endgenerate

    // Scoreboard state register, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy = busy_reg;

endmodule

// File: rtl/regfile_bypass_sb.sv
// Parametrised register file with two combinational read ports, one
// writeback port, optional write-to-read bypass, optional hardwired zero
// register and a busy scoreboard used by decode for RAW hazard detection.
module regfile_bypass_sb
    import cpu_pkg::*;
#(
    parameter int  DATA_W   = CPU_DATA_W,
    parameter int  DEPTH    = CPU_DEPTH,
    parameter bit  ZERO_REG = 1'b0,
    parameter bit  BYPASS   = 1'b1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] RS,
    input  logic [ADDR_W-1:0] RT,
    output logic [DATA_W-1:0] ReadRS,
    output logic [DATA_W-1:0] ReadRT,
    input  logic [ADDR_W-1:0] RD,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] IssueRD,
    input  logic              IssueValid,
    output logic              BusyRS,
    output logic              BusyRT,
    output logic [DEPTH-1:0]  BusyVec
);

    logic [DATA_W-1:0] rf_reg [DEPTH];
    logic              rs_zero;
    logic              rt_zero;
    logic              rs_fwd;
    logic              rt_fwd;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            // Writes to the zero register are dropped so it stays at its reset value
            localparam bit WRITABLE = !(ZERO_REG && (gi == ZERO_IDX));
            logic we;
            assign we = WRITABLE && RegWrite && (RD == ADDR_W'(gi));

            // One storage register, cleared immediately by reset
            always_ff @(posedge Clock or negedge Reset_n) begin
                if (!Reset_n) begin
                    rf_reg[gi] <= '0;
                end else if (we) begin
                    rf_reg[gi] <= WriteData;
                end
            end
        end
    endgenerate

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (Clock),
        .rst_n     (Reset_n),
        .set_idx   (IssueRD),
        .set_valid (IssueValid),
        .clr_idx   (RD),
        .clr_valid (RegWrite),
        .busy      (BusyVec)
    );

    // Decode which read ports address the zero register or are forwarded
    always_comb begin
        rs_zero = ZERO_REG && (RS == ADDR_W'(ZERO_IDX));
        rt_zero = ZERO_REG && (RT == ADDR_W'(ZERO_IDX));
        rs_fwd  = BYPASS && RegWrite && (RD == RS) && !rs_zero;
        rt_fwd  = BYPASS && RegWrite && (RD == RT) && !rt_zero;
    end

    // Read muxes: reset and zero register force 0, then bypass, then storage
    always_comb begin
        ReadRS = rf_reg[RS];
        ReadRT = rf_reg[RT];
        if (!Reset_n || rs_zero) begin
            ReadRS = '0;
        end else if (rs_fwd) begin
            ReadRS = WriteData;
        end
        if (!Reset_n || rt_zero) begin
            ReadRT = '0;
        end else if (rt_fwd) begin
            ReadRT = WriteData;
        end
    end

    // A pending write is no longer a hazard once its data is being forwarded
    always_comb begin
        BusyRS = Reset_n && BusyVec[RS] && !(BYPASS && RegWrite && (RD == RS));
        BusyRT = Reset_n && BusyVec[RT] && !(BYPASS && RegWrite && (RD == RT));
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed testbench for regfile_bypass_sb: a vector table for the default
// configuration plus hand-written sequences for reset, no-bypass,
// hardwired-zero and wide/deep configurations.
module tb_regfile_bypass_sb;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;

    // Shared stimulus for the three 16x8 instances
    reg_idx_t    rs, rt, rd, ird;
    logic [15:0] wd;
    logic        we, iv;

    logic [15:0] d_rs, d_rt, n_rs, n_rt, z_rs, z_rt;
    logic        d_brs, d_brt, n_brs, n_brt, z_brs, z_brt;
    logic [7:0]  d_vec, n_vec, z_vec;

    // 32x32 instance
    logic [4:0]  b_rs, b_rt, b_rd, b_ird;
    logic [31:0] b_wd, b_rrs, b_rrt;
    logic        b_we, b_iv, b_brs, b_brt;
    logic [31:0] b_vec;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int rs, rt, rd, wd, we, ird, iv;
        int e_rs, e_rt, e_brs, e_brt, e_vec;
    } vec_t;

    vec_t tbl [13];

    regfile_bypass_sb #(.ZERO_REG(1'b0), .BYPASS(1'b1)) u_dflt (
        .Clock(clk), .Reset_n(rst_n), .RS(rs), .RT(rt), .ReadRS(d_rs), .ReadRT(d_rt),
        .RD(rd), .WriteData(wd), .RegWrite(we), .IssueRD(ird), .IssueValid(iv),
        .BusyRS(d_brs), .BusyRT(d_brt), .BusyVec(d_vec));

    regfile_bypass_sb #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_nb (
        .Clock(clk), .Reset_n(rst_n), .RS(rs), .RT(rt), .ReadRS(n_rs), .ReadRT(n_rt),
        .RD(rd), .WriteData(wd), .RegWrite(we), .IssueRD(ird), .IssueValid(iv),
        .BusyRS(n_brs), .BusyRT(n_brt), .BusyVec(n_vec));

    regfile_bypass_sb #(.ZERO_REG(1'b1), .BYPASS(1'b1)) u_zr (
        .Clock(clk), .Reset_n(rst_n), .RS(rs), .RT(rt), .ReadRS(z_rs), .ReadRT(z_rt),
        .RD(rd), .WriteData(wd), .RegWrite(we), .IssueRD(ird), .IssueValid(iv),
        .BusyRS(z_brs), .BusyRT(z_brt), .BusyVec(z_vec));

    regfile_bypass_sb #(.DATA_W(32), .DEPTH(32)) u_big (
        .Clock(clk), .Reset_n(rst_n), .RS(b_rs), .RT(b_rt), .ReadRS(b_rrs), .ReadRT(b_rrt),
        .RD(b_rd), .WriteData(b_wd), .RegWrite(b_we), .IssueRD(b_ird), .IssueValid(b_iv),
        .BusyRS(b_brs), .BusyRT(b_brt), .BusyVec(b_vec));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic idle_inputs();
        we = 1'b0; iv = 1'b0; rd = '0; ird = '0; wd = '0; rs = '0; rt = '0;
        b_we = 1'b0; b_iv = 1'b0; b_rd = '0; b_ird = '0; b_wd = '0; b_rs = '0; b_rt = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //        rs rt rd  wd      we ird iv  e_rs    e_rt    brs brt vec
        tbl[0]  = '{0, 7, 0, 'h0000, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h00};
        tbl[1]  = '{3, 3, 3, 'hBEEF, 1, 0, 0, 'hBEEF, 'hBEEF, 0, 0, 'h00};
        tbl[2]  = '{3, 5, 0, 'h0000, 0, 5, 1, 'hBEEF, 'h0000, 0, 0, 'h00};
        tbl[3]  = '{5, 5, 0, 'h0000, 0, 0, 0, 'h0000, 'h0000, 1, 1, 'h20};
        tbl[4]  = '{3, 5, 5, 'h1234, 1, 0, 0, 'hBEEF, 'h1234, 0, 0, 'h20};
        tbl[5]  = '{5, 5, 0, 'h0000, 0, 0, 0, 'h1234, 'h1234, 0, 0, 'h00};
        tbl[6]  = '{2, 2, 2, 'h0042, 1, 2, 1, 'h0042, 'h0042, 0, 0, 'h00};
        tbl[7]  = '{2, 0, 0, 'h0000, 0, 0, 0, 'h0042, 'h0000, 1, 0, 'h04};
        tbl[8]  = '{0, 2, 0, 'hFFFF, 1, 0, 1, 'hFFFF, 'h0042, 0, 1, 'h04};
        tbl[9]  = '{0, 1, 0, 'h0000, 0, 0, 0, 'hFFFF, 'h0000, 1, 0, 'h05};
        tbl[10] = '{2, 1, 0, 'h0000, 0, 2, 1, 'h0042, 'h0000, 1, 0, 'h05};
        tbl[11] = '{2, 0, 2, 'h0043, 1, 0, 0, 'h0043, 'hFFFF, 0, 1, 'h05};
        tbl[12] = '{2, 0, 0, 'h0000, 0, 0, 0, 'h0043, 'hFFFF, 0, 1, 'h01};

        // Reset state while held in reset
        rst_n = 1'b0;
        idle_inputs();
        rt = 3'd7;
        #1;
        chk("rst_read_rs", 32'(d_rs), 32'h0);
        chk("rst_read_rt", 32'(d_rt), 32'h0);
        chk("rst_busyvec", 32'(d_vec), 32'h0);
        chk("rst_busy_rs", 32'(d_brs), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven sequence on the default configuration
        for (int i = 0; i < 13; i++) begin
            rs = 3'(tbl[i].rs);  rt = 3'(tbl[i].rt);  rd = 3'(tbl[i].rd);
            wd = 16'(tbl[i].wd); we = 1'(tbl[i].we);
            ird = 3'(tbl[i].ird); iv = 1'(tbl[i].iv);
            #2;
            chk($sformatf("v%0d_read_rs", i), 32'(d_rs), 32'(tbl[i].e_rs));
            chk($sformatf("v%0d_read_rt", i), 32'(d_rt), 32'(tbl[i].e_rt));
            chk($sformatf("v%0d_busy_rs", i), 32'(d_brs), 32'(tbl[i].e_brs));
            chk($sformatf("v%0d_busy_rt", i), 32'(d_brt), 32'(tbl[i].e_brt));
            chk($sformatf("v%0d_busyvec", i), 32'(d_vec), 32'(tbl[i].e_vec));
            next_cycle();
        end

        // Reset asserted mid-cycle during a write and an issue
        we = 1'b1; rd = 3'd4; wd = 16'hAAAA; iv = 1'b1; ird = 3'd4; rs = 3'd4; rt = 3'd0;
        #2;
        chk("pre_rst_bypass", 32'(d_rs), 32'hAAAA);
        rst_n = 1'b0;
        #1;
        chk("midrst_read_rs", 32'(d_rs), 32'h0);
        chk("midrst_read_rt", 32'(d_rt), 32'h0);
        chk("midrst_busyvec", 32'(d_vec), 32'h0);
        chk("midrst_busy_rt", 32'(d_brt), 32'h0);
        next_cycle();
        chk("inrst_busyvec", 32'(d_vec), 32'h0);
        idle_inputs();
        rs = 3'd4;
        rst_n = 1'b1;
        #2;
        chk("postrst_reg4", 32'(d_rs), 32'h0);
        chk("postrst_reg0", 32'(d_rt), 32'h0);
        chk("postrst_busyvec", 32'(d_vec), 32'h0);

        // No bypass: old value during the write cycle, new value after the edge
        next_cycle();
        we = 1'b1; rd = 3'd3; wd = 16'hBEEF; rs = 3'd3;
        #2;
        chk("nb_same_cycle", 32'(n_rs), 32'h0);
        chk("zr_bypass_reg3", 32'(z_rs), 32'hBEEF);
        next_cycle();
        we = 1'b0;
        #2;
        chk("nb_next_cycle", 32'(n_rs), 32'hBEEF);

        // Hardwired zero: writes, issues and bypass to register 0 are ignored
        next_cycle();
        we = 1'b1; rd = 3'd0; wd = 16'hFFFF; iv = 1'b1; ird = 3'd0; rs = 3'd0; rt = 3'd3;
        #2;
        chk("zr_no_bypass", 32'(z_rs), 32'h0);
        chk("dflt_bypass_r0", 32'(d_rs), 32'hFFFF);
        chk("zr_read_reg3", 32'(z_rt), 32'hBEEF);
        next_cycle();
        we = 1'b0; iv = 1'b0;
        #2;
        chk("zr_reg0_read", 32'(z_rs), 32'h0);
        chk("zr_busyvec", 32'(z_vec), 32'h0);
        chk("zr_busy_rs", 32'(z_brs), 32'h0);
        chk("dflt_reg0_read", 32'(d_rs), 32'hFFFF);
        chk("dflt_busyvec", 32'(d_vec), 32'h1);

        // 32-bit, 32-deep configuration: top register write and isolation
        next_cycle();
        b_we = 1'b1; b_rd = 5'd31; b_wd = 32'hDEADBEEF; b_rt = 5'd31; b_rs = 5'd30;
        next_cycle();
        b_we = 1'b0;
        #2;
        chk("big_read_r31", b_rrt, 32'hDEADBEEF);
        chk("big_read_r30", b_rrs, 32'h0);
        for (int j = 0; j < 31; j++) begin
            b_rt = 5'(j);
            #1;
            chk($sformatf("big_other_r%0d", j), b_rrt, 32'h0);
        end
        chk("big_busyvec", b_vec, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
Parametrised successor to the team's 8x16 register file for the next CPU core generation. It provides configurable width and depth and an optional hardwired-zero register. It adds write-to-read bypass and a per-register busy scoreboard so decode can detect RAW hazards on in-flight writebacks. The block sits between decode (read/issue) and writeback (write/clear).

Parameters:
DATA_W, 16, register width in bits
DEPTH, 8, number of registers; power of two, at least 2
ADDR_W, $clog2(DEPTH), register index width (derived, not overridden)
ZERO_REG, 0, 1 = register 0 reads as 0, ignores writes, never goes busy
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports

Ports:
Clock  input  1  single clock; all state updates on its rising edge
Reset_n  input  1  reset is asynchronous and active-low
RS  input  ADDR_W  read port A index
RT  input  ADDR_W  read port B index
ReadRS  output  DATA_W  read port A data (combinational)
ReadRT  output  DATA_W  read port B data (combinational)
RD  input  ADDR_W  writeback index
WriteData  input  DATA_W  writeback data
RegWrite  input  1  writeback strobe; writes RD and clears its busy bit
IssueRD  input  ADDR_W  destination of newly issued instruction
IssueValid  input  1  marks IssueRD busy at next edge
BusyRS  output  1  RS has a pending write not yet available
BusyRT  output  1  RT has a pending write not yet available
BusyVec  output  DEPTH  raw scoreboard state, bit i = register i busy

Behaviour:
- Reset (Reset_n low, asynchronous): all registers = 0, all busy bits = 0, immediately and held while low. Writes, issues and bypass are ignored during reset. ReadRS = ReadRT = 0, BusyRS = BusyRT = 0, BusyVec = 0.
- Write: at a rising edge with RegWrite=1, Registers[RD] <= WriteData. The write is suppressed when ZERO_REG=1 and RD=0.
- Read: combinational, zero latency. With ZERO_REG=1, index 0 returns 0.
- Bypass (BYPASS=1): if RegWrite=1 and RD==RS, ReadRS = WriteData in the same cycle; the same rule applies to RT. Bypass does not apply to reg 0 when ZERO_REG=1. With BYPASS=0, the new value is visible the cycle after the edge.
- Scoreboard update at each edge, per register i:
  - set if IssueValid and IssueRD==i
  - clear if RegWrite and RD==i
  - if set and clear hit the same i in the same cycle, set wins (a new producer supersedes the retiring one)
  - with ZERO_REG=1, bit 0 is forced to 0
- BusyRS = busy[RS] AND NOT (BYPASS and RegWrite and RD==RS). BusyRT is analogous. Both are combinational from current state.
- Issue to an already-busy register: the bit stays 1 (no counting). A single writeback clears it; the issue stage must avoid WAW in flight.
- RegWrite to a non-busy register is a legal write; busy stays 0.
- Out-of-range indices cannot occur because DEPTH is a power of two.

Decomposition:
- Shared package cpu_pkg: DATA_W/DEPTH defaults, reg_idx_t typedef, ZERO_IDX constant.
- One sub-module, rf_scoreboard: busy vector with set/clear priority and the ZERO_REG mask. The storage array and bypass muxes stay in the top module.

Test Plan:
- Reset then read all indices -> ReadRS = ReadRT = 0, BusyVec = 0. Assert Reset_n low mid-write -> the register stays 0 and BusyVec = 0 immediately.
- RegWrite RD=3, WriteData=16'hBEEF, RS=3 same cycle -> with BYPASS=1, ReadRS = BEEF in that cycle. With BYPASS=0, ReadRS = old value (0), then BEEF the next cycle.
- IssueValid, IssueRD=5 -> BusyVec[5] = 1 the next cycle, and BusyRT = 1 with RT=5. Then RegWrite RD=5, data 16'h1234, RT=5 -> BusyRT = 0 and ReadRT = 1234 in that cycle (BYPASS=1); BusyVec[5] = 0 after the edge.
- Same cycle: IssueValid IssueRD=2 and RegWrite RD=2 data 16'h0042 -> after the edge BusyVec[2] = 1 and Registers[2] = 0042.
- ZERO_REG=1: RegWrite RD=0 data FFFF, IssueValid IssueRD=0 -> ReadRS(RS=0) = 0, BusyVec[0] = 0, no bypass.
- DATA_W=32, DEPTH=32: write 32'hDEADBEEF to reg 31, read via RT=31 -> DEADBEEF the next cycle. Other registers are unchanged.
